// File: rtl/dot_accum.sv
`default_nettype none
// ============================================================================
//  Module      : dot_accum
//  Description : Sums every LEN consecutive 16-bit products from the 8x8
//                multiplier into one ACC_W-bit dot-product result. Completed
//                results are queued in a first-word-fall-through FIFO and
//                delivered over a valid/ready handshake.
//
//  Parameters  : LEN    products per dot product (>= 1)
//                ACC_W  accumulator / result width (>= 16 + clog2(LEN))
//                DEPTH  result FIFO entries (power of two, >= 2)
//
//  Ports       : clk        clock, rising edge
//                rst        synchronous active-high reset
//                in_valid   product valid (multiplier done)
//                in_data    16-bit unsigned product (multiplier y)
//                in_ready   block can accept a product this cycle
//                clear      abort the partial sum in progress
//                out_valid  FIFO head holds a result
//                out_ready  consumer takes the head this cycle
//                out_data   FIFO head result (zero when empty)
//                drop_err   sticky: a product arrived while in_ready was low
//
//  Revision    : 1.0  initial release
// ============================================================================
module dot_accum #(
    parameter int LEN   = 8,
    parameter int ACC_W = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             drop_err
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(LEN - 1);
    localparam logic [c_PTR_W:0]   c_OCC_FULL = (c_PTR_W + 1)'(DEPTH);

    // Accumulator state
    logic [ACC_W-1:0]   r_acc;
    logic [c_CNT_W-1:0] r_cnt;

    // Result FIFO state
    logic [ACC_W-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W:0]   r_occ;
    logic               r_drop;

    logic               w_full;
    logic               w_accept;
    logic               w_last;
    logic               w_push;
    logic               w_pop;
    logic [ACC_W-1:0]   w_sum;

    // in_ready comes only from registered occupancy, so there is no
    // combinational path from out_ready back to the upstream sequencer.
    assign w_full    = (r_occ == c_OCC_FULL);
    assign in_ready  = ~w_full;

    // clear takes priority over an accept: the product is silently discarded.
    assign w_accept  = in_valid & ~w_full & ~clear;
    assign w_last    = (r_cnt == c_CNT_LAST);
    assign w_push    = w_accept & w_last;
    assign w_pop     = out_valid & out_ready;
    assign w_sum     = r_acc + ACC_W'(in_data);

    assign out_valid = (r_occ != '0);
    assign out_data  = out_valid ? r_mem[r_rptr] : '0;
    assign drop_err  = r_drop;

    // Partial-sum accumulator and product counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    // FIFO storage; contents need no reset because occupancy gates the read.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wptr] <= w_sum;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + (c_PTR_W + 1)'(1);
                2'b01:   r_occ <= r_occ - (c_PTR_W + 1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Sticky drop flag: any product offered while full is lost, even if a
    // clear arrives in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= 1'b0;
        end else if (in_valid && w_full) begin
            r_drop <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dot_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dot_accum
//  Description : Self-checking bench for dot_accum. Two instances are run
//                side by side: one with LEN=4 and one with LEN=1, both with
//                a 4-entry result FIFO. Directed scenarios use constant
//                expectations; a randomized phase is compared cycle by cycle
//                against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dot_accum;

    localparam int c_L4  = 4;
    localparam int c_L1  = 1;
    localparam int c_DEP = 4;

    logic        clk;
    logic        rst;

    logic        iv4, clr4, or4, ir4, ov4, de4;
    logic [15:0] id4;
    logic [31:0] od4;

    logic        iv1, clr1, or1, ir1, ov1, de1;
    logic [15:0] id1;
    logic [31:0] od1;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: partial sum, product count, queued results.
    bit [31:0] m_s4, m_s1;
    int        m_n4, m_n1;
    bit        m_d4, m_d1;
    bit [31:0] m_q4[$];
    bit [31:0] m_q1[$];

    dot_accum #(.LEN(c_L4), .ACC_W(32), .DEPTH(c_DEP)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_data(id4), .in_ready(ir4),
        .clear(clr4), .out_valid(ov4), .out_ready(or4), .out_data(od4),
        .drop_err(de4)
    );

    dot_accum #(.LEN(c_L1), .ACC_W(32), .DEPTH(c_DEP)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_data(id1), .in_ready(ir1),
        .clear(clr1), .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .drop_err(de1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock: update the model from the inputs present at the
    // edge, then sample the DUTs 1 ns after the edge.
    task automatic step();
        bit rdy, pop;
        if (rst) begin
            m_q4.delete(); m_s4 = 0; m_n4 = 0; m_d4 = 0;
            m_q1.delete(); m_s1 = 0; m_n1 = 0; m_d1 = 0;
        end else begin
            rdy = (m_q4.size() < c_DEP);
            pop = (m_q4.size() != 0) && or4;
            if (iv4 && !rdy) m_d4 = 1;
            if (pop) m_q4.delete(0);
            if (clr4) begin
                m_s4 = 0; m_n4 = 0;
            end else if (iv4 && rdy) begin
                m_s4 = m_s4 + 32'(id4);
                m_n4++;
                if (m_n4 == c_L4) begin
                    m_q4.push_back(m_s4); m_s4 = 0; m_n4 = 0;
                end
            end
            rdy = (m_q1.size() < c_DEP);
            pop = (m_q1.size() != 0) && or1;
            if (iv1 && !rdy) m_d1 = 1;
            if (pop) m_q1.delete(0);
            if (clr1) begin
                m_s1 = 0; m_n1 = 0;
            end else if (iv1 && rdy) begin
                m_s1 = m_s1 + 32'(id1);
                m_n1++;
                if (m_n1 == c_L1) begin
                    m_q1.push_back(m_s1); m_s1 = 0; m_n1 = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iv4 = 0; id4 = 0; clr4 = 0; or4 = 0;
        iv1 = 0; id1 = 0; clr1 = 0; or1 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
        n_chk++; if (ov4 !== 1'b0) $display("FAIL reset_ov4 got %b want 0", ov4); else n_pass++;
        n_chk++; if (ir4 !== 1'b1) $display("FAIL reset_ir4 got %b want 1", ir4); else n_pass++;
        n_chk++; if (de4 !== 1'b0) $display("FAIL reset_de4 got %b want 0", de4); else n_pass++;
        n_chk++; if (od4 !== 32'd0) $display("FAIL reset_od4 got %0d want 0", od4); else n_pass++;
        n_chk++; if (ov1 !== 1'b0 || ir1 !== 1'b1 || de1 !== 1'b0 || od1 !== 32'd0)
            $display("FAIL reset_dut1 got ov=%b ir=%b de=%b od=%0d want 0/1/0/0", ov1, ir1, de1, od1);
        else n_pass++;
    endtask

    // Four products summed; result visible for exactly one cycle.
    task automatic test_basic_sum();
        or4 = 1;
        for (int i = 1; i <= 4; i++) begin
            iv4 = 1; id4 = 16'(i);
            step();
            if (i < 4) begin
                n_chk++; if (ov4 !== 1'b0) $display("FAIL basic_early_valid step %0d got %b want 0", i, ov4); else n_pass++;
            end
        end
        n_chk++; if (ov4 !== 1'b1 || od4 !== 32'd10)
            $display("FAIL basic_result got ov=%b od=%0d want 1/10", ov4, od4);
        else n_pass++;
        iv4 = 0;
        step();
        n_chk++; if (ov4 !== 1'b0) $display("FAIL basic_one_cycle got ov=%b want 0", ov4); else n_pass++;
        n_chk++; if (de4 !== 1'b0) $display("FAIL basic_drop got %b want 0", de4); else n_pass++;
    endtask

    // Maximum products, then two back-to-back groups of ones.
    task automatic test_max_and_back_to_back();
        or4 = 1;
        for (int i = 0; i < 4; i++) begin
            iv4 = 1; id4 = 16'd65025;
            step();
        end
        n_chk++; if (ov4 !== 1'b1 || od4 !== 32'd260100)
            $display("FAIL max_result got ov=%b od=%0d want 1/260100", ov4, od4);
        else n_pass++;
        for (int i = 1; i <= 8; i++) begin
            iv4 = 1; id4 = 16'd1;
            step();
            if (i == 4 || i == 8) begin
                n_chk++; if (ov4 !== 1'b1 || od4 !== 32'd4)
                    $display("FAIL b2b_result at %0d got ov=%b od=%0d want 1/4", i, ov4, od4);
                else n_pass++;
            end
        end
        iv4 = 0;
        step();
        n_chk++; if (ov4 !== 1'b0) $display("FAIL b2b_drain got ov=%b want 0", ov4); else n_pass++;
    endtask

    // LEN=1 instance: fill FIFO, drop one, drain in order.
    task automatic test_full_and_drop();
        or1 = 0;
        for (int i = 5; i <= 8; i++) begin
            iv1 = 1; id1 = 16'(i);
            step();
            if (i == 7) begin
                n_chk++; if (ir1 !== 1'b1) $display("FAIL full_ready_early got %b want 1", ir1); else n_pass++;
            end
        end
        n_chk++; if (ir1 !== 1'b0) $display("FAIL full_ready got %b want 0", ir1); else n_pass++;
        iv1 = 1; id1 = 16'd99;
        step();
        n_chk++; if (de1 !== 1'b1) $display("FAIL drop_flag got %b want 1", de1); else n_pass++;
        n_chk++; if (ov1 !== 1'b1 || od1 !== 32'd5)
            $display("FAIL full_head_stable got ov=%b od=%0d want 1/5", ov1, od1);
        else n_pass++;
        iv1 = 0; or1 = 1;
        for (int i = 6; i <= 8; i++) begin
            step();
            n_chk++; if (ov1 !== 1'b1 || od1 !== 32'(i))
                $display("FAIL drain_order got ov=%b od=%0d want 1/%0d", ov1, od1, i);
            else n_pass++;
            if (i == 6) begin
                n_chk++; if (ir1 !== 1'b1) $display("FAIL ready_after_pop got %b want 1", ir1); else n_pass++;
            end
        end
        step();
        n_chk++; if (ov1 !== 1'b0 || od1 !== 32'd0)
            $display("FAIL drain_empty got ov=%b od=%0d want 0/0", ov1, od1);
        else n_pass++;
        or1 = 0;
    endtask

    // clear coincident with a product wins; that product is not a drop.
    task automatic test_clear();
        or4 = 1;
        iv4 = 1; id4 = 16'd1; step();
        id4 = 16'd2; step();
        id4 = 16'd100; clr4 = 1; step();
        clr4 = 0;
        for (int i = 3; i <= 6; i++) begin
            id4 = 16'(i);
            step();
            if (i < 6) begin
                n_chk++; if (ov4 !== 1'b0) $display("FAIL clear_early_valid at %0d got %b want 0", i, ov4); else n_pass++;
            end
        end
        n_chk++; if (ov4 !== 1'b1 || od4 !== 32'd18)
            $display("FAIL clear_result got ov=%b od=%0d want 1/18", ov4, od4);
        else n_pass++;
        n_chk++; if (de4 !== 1'b0) $display("FAIL clear_drop got %b want 0", de4); else n_pass++;
        iv4 = 0;
        step();
    endtask

    // Simultaneous push and pop keeps occupancy and order.
    task automatic test_push_pop();
        or4 = 0;
        for (int i = 0; i < 4; i++) begin iv4 = 1; id4 = 16'd1; step(); end
        for (int i = 0; i < 4; i++) begin iv4 = 1; id4 = 16'd2; step(); end
        for (int i = 0; i < 3; i++) begin iv4 = 1; id4 = 16'd2; step(); end
        n_chk++; if (od4 !== 32'd4) $display("FAIL pp_head_before got %0d want 4", od4); else n_pass++;
        id4 = 16'd3; or4 = 1;
        step();
        n_chk++; if (ov4 !== 1'b1 || od4 !== 32'd8 || ir4 !== 1'b1)
            $display("FAIL pp_after got ov=%b od=%0d ir=%b want 1/8/1", ov4, od4, ir4);
        else n_pass++;
        iv4 = 0;
        step();
        n_chk++; if (ov4 !== 1'b1 || od4 !== 32'd9)
            $display("FAIL pp_second got ov=%b od=%0d want 1/9", ov4, od4);
        else n_pass++;
        step();
        n_chk++; if (ov4 !== 1'b0 || od4 !== 32'd0)
            $display("FAIL pp_empty got ov=%b od=%0d want 0/0", ov4, od4);
        else n_pass++;
    endtask

    // Reset mid-accumulation discards partial sum and queued result.
    task automatic test_reset_mid();
        or4 = 0;
        for (int i = 0; i < 6; i++) begin iv4 = 1; id4 = 16'd1; step(); end
        n_chk++; if (ov4 !== 1'b1) $display("FAIL rm_queued got %b want 1", ov4); else n_pass++;
        iv4 = 0; rst = 1;
        step();
        rst = 0;
        n_chk++; if (ov4 !== 1'b0 || ir4 !== 1'b1 || od4 !== 32'd0)
            $display("FAIL rm_after_rst got ov=%b ir=%b od=%0d want 0/1/0", ov4, ir4, od4);
        else n_pass++;
        or4 = 1;
        for (int i = 1; i <= 4; i++) begin
            iv4 = 1; id4 = 16'd1;
            step();
            if (i < 4) begin
                n_chk++; if (ov4 !== 1'b0) $display("FAIL rm_stale at %0d got ov=%b want 0", i, ov4); else n_pass++;
            end
        end
        n_chk++; if (ov4 !== 1'b1 || od4 !== 32'd4)
            $display("FAIL rm_result got ov=%b od=%0d want 1/4", ov4, od4);
        else n_pass++;
        iv4 = 0;
        step();
    endtask

    // Random traffic on both instances against the reference model.
    task automatic test_random();
        bit [31:0] e4, e1;
        for (int c = 0; c < 400; c++) begin
            iv4  = ($urandom_range(0, 9) < 7);
            id4  = 16'($urandom);
            clr4 = ($urandom_range(0, 19) == 0);
            or4  = ($urandom_range(0, 9) < 4);
            iv1  = ($urandom_range(0, 9) < 6);
            id1  = 16'($urandom);
            clr1 = ($urandom_range(0, 19) == 0);
            or1  = ($urandom_range(0, 9) < 5);
            step();
            e4 = (m_q4.size() != 0) ? m_q4[0] : 32'd0;
            e1 = (m_q1.size() != 0) ? m_q1[0] : 32'd0;
            n_chk++; if (ov4 !== (m_q4.size() != 0) || od4 !== e4)
                $display("FAIL rnd4_out cyc %0d got ov=%b od=%0d want %b/%0d", c, ov4, od4, (m_q4.size() != 0), e4);
            else n_pass++;
            n_chk++; if (ir4 !== (m_q4.size() < c_DEP) || de4 !== m_d4)
                $display("FAIL rnd4_flags cyc %0d got ir=%b de=%b want %b/%b", c, ir4, de4, (m_q4.size() < c_DEP), m_d4);
            else n_pass++;
            n_chk++; if (ov1 !== (m_q1.size() != 0) || od1 !== e1)
                $display("FAIL rnd1_out cyc %0d got ov=%b od=%0d want %b/%0d", c, ov1, od1, (m_q1.size() != 0), e1);
            else n_pass++;
            n_chk++; if (ir1 !== (m_q1.size() < c_DEP) || de1 !== m_d1)
                $display("FAIL rnd1_flags cyc %0d got ir=%b de=%b want %b/%b", c, ir1, de1, (m_q1.size() < c_DEP), m_d1);
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_basic_sum();
        test_max_and_back_to_back();
        test_full_and_drop();
        test_clear();
        test_push_pop();
        test_reset_mid();
        test_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
